// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state type, lane codes and timer sizing for the parking lane arbiter
package parking_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, GATE_OPEN, ERROR} state_e;

  localparam logic LANE_ENTRY = 1'b0;
  localparam logic LANE_EXIT  = 1'b1;

  // One shared timer serves both SCAN and GATE_OPEN, so size it for the longer window.
  function automatic int timer_width(input int scan_timeout, input int gate_timeout);
    int longest;
    longest = (scan_timeout > gate_timeout) ? scan_timeout : gate_timeout;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/parking_occupancy_counter.sv
// rtl/parking_occupancy_counter.sv - saturating up/down car counter with registered full flag
module parking_occupancy_counter #(
  parameter int CAPACITY = 64,
  parameter int CW       = $clog2(CAPACITY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && (count_q < CW'(CAPACITY))) begin
      count_d = count_q + CW'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
    full_d = (count_d == CW'(CAPACITY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;

endmodule

// File: rtl/parking_lane_arbiter.sv
// rtl/parking_lane_arbiter.sv - shares one RFID reader between entry and exit lanes and sequences the gates
module parking_lane_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 64,
  parameter int SCAN_TIMEOUT = 100,
  parameter int GATE_TIMEOUT = 500
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           car_detect_entry,
  input  logic                           car_detect_exit,
  input  logic                           rfid_valid,
  input  logic                           rfid_fail,
  input  logic                           entry_passed,
  input  logic                           exit_passed,
  output logic                           activate_rfid,
  output logic                           rfid_lane,
  output logic                           open_entry_gate,
  output logic                           open_exit_gate,
  output logic                           assert_error,
  output logic                           lot_full,
  output logic [$clog2(CAPACITY+1)-1:0]  occupancy
);

  localparam int TW = timer_width(SCAN_TIMEOUT, GATE_TIMEOUT);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_entry_q, pend_entry_d;
  logic          pend_exit_q, pend_exit_d;
  logic          last_grant_q, last_grant_d;
  logic          activate_rfid_q, activate_rfid_d;
  logic          rfid_lane_q, rfid_lane_d;
  logic          open_entry_gate_q, open_entry_gate_d;
  logic          open_exit_gate_q, open_exit_gate_d;
  logic          assert_error_q, assert_error_d;

  logic elig_entry, elig_exit, lane_passed, service_end;
  logic serving_entry, serving_exit;
  logic occ_inc, occ_dec, occ_full;

  assign elig_entry    = pend_entry_q && !occ_full;
  assign elig_exit     = pend_exit_q;
  assign serving_entry = (state_q != IDLE) && (last_grant_q == LANE_ENTRY);
  assign serving_exit  = (state_q != IDLE) && (last_grant_q == LANE_EXIT);
  assign lane_passed   = (last_grant_q == LANE_ENTRY) ? entry_passed : exit_passed;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    service_end  = 1'b0;
    occ_inc      = 1'b0;
    occ_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (elig_entry && elig_exit) begin
          last_grant_d = ~last_grant_q;
          state_d      = SCAN;
        end else if (elig_entry) begin
          last_grant_d = LANE_ENTRY;
          state_d      = SCAN;
        end else if (elig_exit) begin
          last_grant_d = LANE_EXIT;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        timer_d = timer_q + TW'(1);
        if (rfid_fail) begin
          state_d = ERROR;
        end else if (rfid_valid) begin
          state_d = GATE_OPEN;
          timer_d = '0;
        end else if (timer_q == TW'(SCAN_TIMEOUT - 1)) begin
          state_d = ERROR;
        end
      end
      GATE_OPEN: begin
        timer_d = timer_q + TW'(1);
        if (lane_passed) begin
          state_d     = IDLE;
          service_end = 1'b1;
          occ_inc     = (last_grant_q == LANE_ENTRY);
          occ_dec     = (last_grant_q == LANE_EXIT);
        end else if (timer_q == TW'(GATE_TIMEOUT - 1)) begin
          state_d = ERROR;
        end
      end
      ERROR: begin
        state_d     = IDLE;
        service_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A lane's own detector is ignored while it is being served; its flag drops when service ends.
    pend_entry_d = pend_entry_q | (car_detect_entry & ~serving_entry);
    pend_exit_d  = pend_exit_q | (car_detect_exit & ~serving_exit);
    if (service_end && (last_grant_q == LANE_ENTRY)) pend_entry_d = 1'b0;
    if (service_end && (last_grant_q == LANE_EXIT))  pend_exit_d  = 1'b0;

    // Outputs are a registered decode of the current state, so they trail the state by one cycle.
    activate_rfid_d   = (state_q == SCAN);
    open_entry_gate_d = (state_q == GATE_OPEN) && (last_grant_q == LANE_ENTRY);
    open_exit_gate_d  = (state_q == GATE_OPEN) && (last_grant_q == LANE_EXIT);
    assert_error_d    = (state_q == ERROR);
    rfid_lane_d       = ((state_q == SCAN) || (state_q == GATE_OPEN)) ? last_grant_q : rfid_lane_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      timer_q           <= '0;
      pend_entry_q      <= 1'b0;
      pend_exit_q       <= 1'b0;
      last_grant_q      <= LANE_EXIT;
      activate_rfid_q   <= 1'b0;
      rfid_lane_q       <= 1'b0;
      open_entry_gate_q <= 1'b0;
      open_exit_gate_q  <= 1'b0;
      assert_error_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      timer_q           <= timer_d;
      pend_entry_q      <= pend_entry_d;
      pend_exit_q       <= pend_exit_d;
      last_grant_q      <= last_grant_d;
      activate_rfid_q   <= activate_rfid_d;
      rfid_lane_q       <= rfid_lane_d;
      open_entry_gate_q <= open_entry_gate_d;
      open_exit_gate_q  <= open_exit_gate_d;
      assert_error_q    <= assert_error_d;
    end
  end

  parking_occupancy_counter #(
    .CAPACITY (CAPACITY)
  ) u_occupancy (
    .clk   (clk),
    .reset (reset),
    .inc   (occ_inc),
    .dec   (occ_dec),
    .count (occupancy),
    .full  (occ_full)
  );

  assign lot_full        = occ_full;
  assign activate_rfid   = activate_rfid_q;
  assign rfid_lane       = rfid_lane_q;
  assign open_entry_gate = open_entry_gate_q;
  assign open_exit_gate  = open_exit_gate_q;
  assign assert_error    = assert_error_q;

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// tb/tb_parking_lane_arbiter.sv - directed and randomized checks of parking_lane_arbiter against a lane-service model
module tb_parking_lane_arbiter;

  localparam int CAP     = 2;
  localparam int SCAN_TO = 8;
  localparam int GATE_TO = 16;

  localparam int PH_IDLE = 0;
  localparam int PH_SCAN = 1;
  localparam int PH_GATE = 2;
  localparam int PH_ERR  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       car_detect_entry, car_detect_exit;
  logic       rfid_valid, rfid_fail, entry_passed, exit_passed;
  logic       activate_rfid, rfid_lane, open_entry_gate, open_exit_gate;
  logic       assert_error, lot_full;
  logic [1:0] occupancy;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: which lane is in service, how far along, and what the registered outputs should read.
  int       m_ph, m_age, m_occ;
  logic     m_lane;
  logic [1:0] m_pend;
  logic     e_act, e_lane, e_gate_entry, e_gate_exit, e_err;

  int act_cycles, err_cycles, entry_gate_cycles, exit_gate_cycles;

  parking_lane_arbiter #(
    .CAPACITY     (CAP),
    .SCAN_TIMEOUT (SCAN_TO),
    .GATE_TIMEOUT (GATE_TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .car_detect_entry (car_detect_entry),
    .car_detect_exit  (car_detect_exit),
    .rfid_valid       (rfid_valid),
    .rfid_fail        (rfid_fail),
    .entry_passed     (entry_passed),
    .exit_passed      (exit_passed),
    .activate_rfid    (activate_rfid),
    .rfid_lane        (rfid_lane),
    .open_entry_gate  (open_entry_gate),
    .open_exit_gate   (open_exit_gate),
    .assert_error     (assert_error),
    .lot_full         (lot_full),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = PH_IDLE; m_age = 0; m_occ = 0; m_lane = 1'b1; m_pend = 2'b00;
    e_act = 1'b0; e_lane = 1'b0; e_gate_entry = 1'b0; e_gate_exit = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] det, passed, new_pend;
    logic want_entry, want_exit;
    if (reset) begin
      model_reset();
      return;
    end
    det    = {car_detect_exit, car_detect_entry};
    passed = {exit_passed, entry_passed};
    e_act        = (m_ph == PH_SCAN);
    e_gate_entry = (m_ph == PH_GATE) && (m_lane == 1'b0);
    e_gate_exit  = (m_ph == PH_GATE) && (m_lane == 1'b1);
    e_err        = (m_ph == PH_ERR);
    if (m_ph == PH_SCAN || m_ph == PH_GATE) e_lane = m_lane;
    for (int l = 0; l < 2; l++)
      new_pend[l] = m_pend[l] || (det[l] && !(m_ph != PH_IDLE && int'(m_lane) == l));
    case (m_ph)
      PH_IDLE: begin
        want_entry = m_pend[0] && (m_occ < CAP);
        want_exit  = m_pend[1];
        if (want_entry || want_exit) begin
          if (want_entry && want_exit) m_lane = ~m_lane;
          else m_lane = want_exit;
          m_ph = PH_SCAN; m_age = 0;
        end
      end
      PH_SCAN: begin
        if (rfid_fail) m_ph = PH_ERR;
        else if (rfid_valid) begin m_ph = PH_GATE; m_age = 0; end
        else if (m_age == SCAN_TO - 1) m_ph = PH_ERR;
        else m_age++;
      end
      PH_GATE: begin
        if (passed[m_lane]) begin
          if (m_lane == 1'b0) m_occ = m_occ + 1;
          else if (m_occ > 0) m_occ = m_occ - 1;
          new_pend[m_lane] = 1'b0;
          m_ph = PH_IDLE;
        end else if (m_age == GATE_TO - 1) m_ph = PH_ERR;
        else m_age++;
      end
      default: begin
        new_pend[m_lane] = 1'b0;
        m_ph = PH_IDLE;
      end
    endcase
    m_pend = new_pend;
  endtask

  task automatic check_outputs();
    chk("activate_rfid", 32'(activate_rfid), 32'(e_act));
    chk("rfid_lane", 32'(rfid_lane), 32'(e_lane));
    chk("open_entry_gate", 32'(open_entry_gate), 32'(e_gate_entry));
    chk("open_exit_gate", 32'(open_exit_gate), 32'(e_gate_exit));
    chk("assert_error", 32'(assert_error), 32'(e_err));
    chk("occupancy", 32'(occupancy), 32'(m_occ));
    chk("lot_full", 32'(lot_full), 32'(m_occ == CAP));
    chk("gate_exclusive", 32'(open_entry_gate & open_exit_gate), 32'd0);
    act_cycles        += int'(activate_rfid);
    err_cycles        += int'(assert_error);
    entry_gate_cycles += int'(open_entry_gate);
    exit_gate_cycles  += int'(open_exit_gate);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_cnt();
    act_cycles = 0; err_cycles = 0; entry_gate_cycles = 0; exit_gate_cycles = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    clr_cnt();
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 40 && m_ph != ph; i++) tick();
  endtask

  task automatic pulse_detect(input logic lane);
    if (lane) car_detect_exit = 1'b1; else car_detect_entry = 1'b1;
    tick();
    car_detect_entry = 1'b0; car_detect_exit = 1'b0;
  endtask

  // Serve whichever lane the arbiter picks; the caller states which lane that should be.
  task automatic serve(input string tag, input logic lane);
    wait_phase(PH_SCAN);
    rfid_valid = 1'b1; tick(); rfid_valid = 1'b0;
    tick();
    chk({tag, "_lane"}, 32'(rfid_lane), 32'(lane));
    if (lane) exit_passed = 1'b1; else entry_passed = 1'b1;
    tick();
    entry_passed = 1'b0; exit_passed = 1'b0;
    ticks(2);
  endtask

  initial begin
    reset = 1'b1;
    car_detect_entry = 1'b0; car_detect_exit = 1'b0;
    rfid_valid = 1'b0; rfid_fail = 1'b0; entry_passed = 1'b0; exit_passed = 1'b0;
    model_reset();
    do_reset();
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    chk("reset_activate", 32'(activate_rfid), 32'd0);

    // Single entry: valid on the third scan cycle, pass two cycles after the gate state.
    pulse_detect(1'b0);
    wait_phase(PH_SCAN);
    ticks(2);
    rfid_valid = 1'b1; tick(); rfid_valid = 1'b0;
    ticks(2);
    entry_passed = 1'b1; tick(); entry_passed = 1'b0;
    ticks(3);
    chk("t1_act_cycles", 32'(act_cycles), 32'd3);
    chk("t1_gate_cycles", 32'(entry_gate_cycles), 32'd3);
    chk("t1_occupancy", 32'(occupancy), 32'd1);
    chk("t1_errors", 32'(err_cycles), 32'd0);

    // Simultaneous detection: entry first, then exit.
    do_reset();
    car_detect_entry = 1'b1; car_detect_exit = 1'b1; tick();
    car_detect_entry = 1'b0; car_detect_exit = 1'b0;
    serve("t2_first", 1'b0);
    serve("t2_second", 1'b1);
    chk("t2_occupancy", 32'(occupancy), 32'd0);
    chk("t2_exit_served", 32'(exit_gate_cycles > 0), 32'd1);

    // Fill the lot, hold an entry, serve an exit, then the held entry.
    do_reset();
    pulse_detect(1'b0); serve("t3_e1", 1'b0);
    pulse_detect(1'b0); serve("t3_e2", 1'b0);
    chk("t3_full", 32'(lot_full), 32'd1);
    chk("t3_occ2", 32'(occupancy), 32'd2);
    clr_cnt();
    pulse_detect(1'b0);
    ticks(6);
    chk("t3_no_scan_when_full", 32'(act_cycles), 32'd0);
    pulse_detect(1'b1);
    wait_phase(PH_SCAN);
    rfid_valid = 1'b1; tick(); rfid_valid = 1'b0;
    tick();
    exit_passed = 1'b1; tick(); exit_passed = 1'b0;
    chk("t3_occ_after_exit", 32'(occupancy), 32'd1);
    chk("t3_not_full", 32'(lot_full), 32'd0);
    wait_phase(PH_SCAN);
    ticks(1);
    chk("t3_held_entry_act", 32'(activate_rfid), 32'd1);
    chk("t3_held_entry_lane", 32'(rfid_lane), 32'd0);
    rfid_fail = 1'b1; tick(); rfid_fail = 1'b0;
    ticks(3);

    // Scan timeout.
    do_reset();
    pulse_detect(1'b0);
    ticks(25);
    chk("t4_act_cycles", 32'(act_cycles), 32'(SCAN_TO));
    chk("t4_error_pulses", 32'(err_cycles), 32'd1);
    chk("t4_occupancy", 32'(occupancy), 32'd0);

    // valid+fail together, then gate timeout.
    do_reset();
    pulse_detect(1'b0);
    wait_phase(PH_SCAN);
    rfid_valid = 1'b1; rfid_fail = 1'b1; tick();
    rfid_valid = 1'b0; rfid_fail = 1'b0;
    ticks(4);
    chk("t5_fail_wins_err", 32'(err_cycles), 32'd1);
    chk("t5_fail_wins_gate", 32'(entry_gate_cycles), 32'd0);
    clr_cnt();
    pulse_detect(1'b0);
    wait_phase(PH_SCAN);
    rfid_valid = 1'b1; tick(); rfid_valid = 1'b0;
    ticks(25);
    chk("t5_gate_cycles", 32'(entry_gate_cycles), 32'(GATE_TO));
    chk("t5_gate_err", 32'(err_cycles), 32'd1);
    chk("t5_gate_occ", 32'(occupancy), 32'd0);

    // Reset with the exit gate open, then an exit at zero occupancy.
    do_reset();
    pulse_detect(1'b0); serve("t6_e1", 1'b0);
    pulse_detect(1'b0); serve("t6_e2", 1'b0);
    pulse_detect(1'b1);
    wait_phase(PH_SCAN);
    rfid_valid = 1'b1; tick(); rfid_valid = 1'b0;
    tick();
    chk("t6_exit_gate_open", 32'(open_exit_gate), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_gate_closed", 32'(open_exit_gate), 32'd0);
    chk("t6_occ_zero", 32'(occupancy), 32'd0);
    clr_cnt();
    pulse_detect(1'b1); serve("t6_underflow", 1'b1);
    chk("t6_no_underflow", 32'(occupancy), 32'd0);
    chk("t6_no_error", 32'(err_cycles), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      reset            = ($urandom_range(199) == 0);
      car_detect_entry = ($urandom_range(3) == 0);
      car_detect_exit  = ($urandom_range(4) == 0);
      rfid_valid       = ($urandom_range(5) == 0);
      rfid_fail        = ($urandom_range(19) == 0);
      entry_passed     = ($urandom_range(5) == 0);
      exit_passed      = ($urandom_range(5) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/parking_lane_arbiter.md
Name: parking_lane_arbiter

Overview:
Controller that shares one RFID reader between the entry lane and the exit lane of the parking lot, and sequences each lane's gate. Tracks lot occupancy against a fixed capacity and blocks entry grants while the lot is full. Scan and gate timeouts are counted internally, so no external timer handshake is needed. Sits between the lane sensors/RFID front end and the gate actuators, replacing per-lane timer start/timeout wiring.

Parameters:
CAPACITY, 64, number of parking spaces; occupancy never exceeds this.
SCAN_TIMEOUT, 100, cycles in SCAN without an RFID result before abort.
GATE_TIMEOUT, 500, cycles a gate may stay open without a pass event before abort.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
car_detect_entry  input  1  car present at entry sensor (level).
car_detect_exit  input  1  car present at exit sensor (level).
rfid_valid  input  1  reader reports valid tag (1-cycle pulse).
rfid_fail  input  1  reader reports validation failure (1-cycle pulse).
entry_passed  input  1  car cleared entry gate (1-cycle pulse).
exit_passed  input  1  car cleared exit gate (1-cycle pulse).
activate_rfid  output  1  reader enable, high throughout SCAN.
rfid_lane  output  1  lane being scanned: 0 = entry, 1 = exit; held through SCAN and GATE_OPEN.
open_entry_gate  output  1  entry gate open command.
open_exit_gate  output  1  exit gate open command.
assert_error  output  1  1-cycle pulse on any abort.
lot_full  output  1  high when occupancy == CAPACITY.
occupancy  output  $clog2(CAPACITY+1)  cars currently in the lot.

Behaviour:
- All outputs are registered. Reset values: all 1-bit outputs 0, occupancy 0, state IDLE, both pending flags 0, last_grant = 1 (exit), so entry wins the first tie.
- Pending flags: pend_entry is set on any cycle with car_detect_entry = 1; pend_exit likewise. A flag is cleared only when its lane's service ends (success or abort). Detection during service of the same lane is ignored.
- Eligibility: the exit lane is always eligible. The entry lane is eligible only if occupancy < CAPACITY.
- Arbitration in IDLE: if exactly one lane is pending and eligible, grant it. If both are, grant the lane != last_grant (round-robin). Grant sets last_grant and rfid_lane. Next state is SCAN.
- SCAN: activate_rfid = 1 and the timer counts from 0.
  - rfid_fail -> ERROR.
  - else rfid_valid -> GATE_OPEN and the timer clears.
  - else if timer == SCAN_TIMEOUT-1 -> ERROR.
  - If rfid_valid and rfid_fail are high in the same cycle, fail wins. rfid_valid on the final timeout cycle wins over the timeout.
- GATE_OPEN: the granted lane's gate output is 1, activate_rfid = 0.
  - The matching passed pulse returns to IDLE. On that edge, occupancy +1 (entry) or -1 (exit) and the lane's pending flag clears.
  - If timer == GATE_TIMEOUT-1 with no pass -> ERROR, occupancy unchanged.
  - A passed pulse for the non-granted lane is ignored.
- ERROR: lasts one cycle. assert_error = 1, all gates and activate_rfid = 0, the granted lane's pending flag clears, then IDLE. The car must be re-detected to retry.
- Latency: detection at edge N sets pending. Grant and SCAN entry take effect at N+1, so activate_rfid is high from N+2. Gate opens the cycle after rfid_valid is sampled.
- Occupancy rules:
  - Saturates at 0; exit_passed at occupancy 0 is a successful exit with no decrement and no error.
  - Cannot exceed CAPACITY, because entry is never granted when full.
  - lot_full is updated in the same cycle as occupancy.
- Reset mid-operation: immediate return to reset values. An open gate closes and occupancy returns to 0.
- Gates are mutually exclusive: at most one of open_entry_gate / open_exit_gate is ever 1.

Decomposition:
- Package parking_pkg holds:
  - state enum {IDLE, SCAN, GATE_OPEN, ERROR};
  - lane constants LANE_ENTRY = 1'b0, LANE_EXIT = 1'b1;
  - a function computing the timer width from max(SCAN_TIMEOUT, GATE_TIMEOUT).
- One natural sub-module: parking_occupancy_counter, a saturating up/down counter with CAPACITY parameter, inc/dec inputs and a full flag. FSM, arbitration and timer live in the top.

Test Plan:
1. CAPACITY=2, SCAN_TIMEOUT=8, GATE_TIMEOUT=16 (all tests). Reset, then car_detect_entry for 1 cycle, rfid_valid 3 cycles after activate_rfid rises, entry_passed 2 cycles later -> activate_rfid high 3 cycles with rfid_lane=0, open_entry_gate high until entry_passed, occupancy 0->1, no assert_error.
2. Both detects asserted in the same cycle after reset, each served with valid+pass -> entry granted first, then exit. Ties resolve in round-robin order; occupancy ends unchanged; gates never open together.
3. Two successful entries bring occupancy to 2 -> lot_full=1. A third car_detect_entry produces no activate_rfid. A pending exit is still served, and on exit_passed occupancy = 1 and lot_full = 0. The held entry is then granted.
4. Entry granted, no RFID response -> activate_rfid high exactly 8 cycles, then 1-cycle assert_error, pend_entry cleared, state IDLE, occupancy unchanged.
5. rfid_valid and rfid_fail in the same cycle -> ERROR, no gate opens. Separately, rfid_valid then no pass for 16 cycles -> gate closes and assert_error pulses.
6. reset asserted while open_exit_gate=1 with occupancy=2 -> next cycle all outputs 0 and occupancy 0. An exit_passed at occupancy 0 is counted as a successful exit with no underflow.
